// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and default constants for the FIFO write-port arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, BURST)
//   DEF_*            : default parameter values used by fifo_wr_arbiter
//   idx_width()      : width of an index into n items, never less than 1
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: returns the first set request found when
// scanning upward from prio_ptr, wrapping past NUM_REQ-1 back to 0.
//   req         in   NUM_REQ   request vector
//   prio_ptr    in   IDX_W     index with highest priority this cycle
//   grant_idx   out  IDX_W     index of the selected request (0 when none)
//   grant_valid out  1         at least one request is set
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   prio_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves one unassigned would infer a latch.
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modular add done by compare/subtract so NUM_REQ need not be 2^n.
            idx = int'(prio_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts for up to MAX_BURST beats; priority then rotates to the
// producer after the owner. No write is issued while fifo_full is high.
//   clk        in   1                    clock
//   rst        in   1                    asynchronous active-low reset
//   req        in   NUM_REQ              producer i has a beat ready
//   req_data   in   NUM_REQ*DATA_WIDTH   lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   ack        out  NUM_REQ              one-hot, beat from producer i accepted
//   fifo_full  in   1                    FIFO full flag
//   wr_en      out  1                    FIFO write enable
//   data_in    out  DATA_WIDTH           FIFO write data
//   busy       out  1                    a burst grant is active
//   owner      out  $clog2(NUM_REQ)      current grant owner, valid when busy
//   stall_cnt  out  CNT_WIDTH            saturating count of full-stalled cycles
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [CNT_WIDTH-1:0]          stall_cnt
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = idx_width(MAX_BURST);
    localparam logic [BW-1:0]        LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [OW-1:0]        LAST_IDX  = OW'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    arb_state_t           state_q, state_d;
    logic [OW-1:0]        prio_ptr_q, prio_ptr_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic [OW-1:0] pick_idx;
    logic          pick_valid;
    logic          beat;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_pick (
        .req         (req),
        .prio_ptr    (prio_ptr_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // A beat needs an active grant, a ready owner and room in the FIFO.
    assign beat = (state_q == BURST) && req[owner_q] && !fifo_full;

    always_comb begin
        state_d     = state_q;
        prio_ptr_d  = prio_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            IDLE: begin
                // Grant is taken regardless of fifo_full; BURST handles stalls.
                if (pick_valid) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (beat && (beat_cnt_q == LAST_BEAT)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    prio_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end else if (!req[owner_q]) begin
                    // Owner withdrew: release the grant early.
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    prio_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else if (stall_cnt_q != CNT_MAX) begin
                    // Owner ready but FIFO full: hold grant, budget untouched.
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            prio_ptr_q  <= '0;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_ptr_q  <= prio_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        ack          = '0;
        ack[owner_q] = beat;
        data_in      = beat ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign wr_en     = beat;
    assign busy      = (state_q == BURST);
    assign owner     = owner_q;
    assign stall_cnt = stall_cnt_q;

endmodule
